serial_frame_rx: RTL and testbench

Serial-to-parallel frame receiver for the week-6 sequential designs. It samples a single-bit serial line `D` once per `Clock` rising edge and recognises framed words: a start bit, `WIDTH` data bits sent LSB first, an optional even-parity bit, and a stop bit. It presents each completed word on `Q` with a one-cycle `Valid` strobe. It is the receiving end of the bit-serial stimulus stream that the team's flip-flop and shift-register benches drive.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/sipo_shift.sv | 38 +++
 rtl/serial_frame_rx.sv | 136 +++++++++++++
 tb/tb_serial_frame_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_t            : FSM encoding (IDLE, DATA, PAR, STOP)
//   SERIAL_IDLE_LEVEL  : line level between frames and for a good stop bit
//   SERIAL_START_LEVEL : line level that marks a start bit
//   parity16           : XOR reduction helper for the even-parity check
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic SERIAL_IDLE_LEVEL  = 1'b1;
  localparam logic SERIAL_START_LEVEL = 1'b0;

  // XOR of all bits; data narrower than 16 bits is zero-extended by the caller.
  function automatic logic parity16(input logic [15:0] i_v);
    return ^i_v;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in / parallel-out right-shift register.
// New bits enter at the MSB, so after WIDTH shifts the first bit sits in bit 0.
// Ports:
//   i_clk    : clock (rising edge)
//   i_rst_n  : asynchronous active-low reset, clears the register
//   i_clear  : synchronous clear (has priority over shift)
//   i_shift  : shift enable
//   i_d      : serial input bit
//   o_q      : parallel contents
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift register state: clear, shift right with new bit at the MSB, or hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= {i_d, r_q[WIDTH-1:1]};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit (0), WIDTH data bits LSB first,
// optional even-parity bit, stop bit (1). One bit per Clock cycle.
// Optional feature macro: SERIAL_PARITY_EN (adds the PAR state and parity check).
// Ports:
//   Clock    : clock, sampling on rising edge
//   Reset    : asynchronous active-low reset
//   D        : serial line, idles high
//   Q        : last correctly received word, held until the next good frame
//   Valid    : one-cycle pulse when Q is updated
//   FrameErr : one-cycle pulse on bad stop bit or parity mismatch
//   Busy     : high from the start-bit edge until the stop-bit edge
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             D,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             FrameErr,
  output logic             Busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_ferr;
  logic             r_busy;

  logic [WIDTH-1:0] w_shift;
  logic             w_shift_en;
  logic             w_clear;
  logic             w_par_ok;

  // The start bit itself is not data: clear in IDLE, shift only in DATA.
  assign w_clear    = (r_state == ST_IDLE) && (D == SERIAL_START_LEVEL);
  assign w_shift_en = (r_state == ST_DATA);

  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_clear (w_clear),
    .i_shift (w_shift_en),
    .i_d     (D),
    .o_q     (w_shift)
  );

`ifdef SERIAL_PARITY_EN
  logic r_par_err;

  // Parity result captured in PAR and consumed in STOP.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_par_err <= 1'b0;
    end else if (r_state == ST_PAR) begin
      r_par_err <= parity16(16'(w_shift)) ^ D;
    end else begin
      r_par_err <= r_par_err;
    end
  end

  assign w_par_ok = ~r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // Frame FSM, bit counter and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (D == SERIAL_START_LEVEL) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST_BIT) begin
            r_cnt <= '0;
`ifdef SERIAL_PARITY_EN
            r_state <= ST_PAR;
`else
            r_state <= ST_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef SERIAL_PARITY_EN
        ST_PAR: begin
          r_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // The stop-bit sample is consumed here, so a 0 never starts a frame.
          if ((D == SERIAL_IDLE_LEVEL) && w_par_ok) begin
            r_q     <= w_shift;
            r_valid <= 1'b1;
          end else begin
            r_ferr <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = r_q;
  assign Valid    = r_valid;
  assign FrameErr = r_ferr;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed testbench for serial_frame_rx (WIDTH=8).
// D is driven 1 time unit after each rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge that just happened.
module tb_serial_frame_rx;

`ifdef SERIAL_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       D     = 1'b1;
  logic [7:0] Q;
  logic       Valid;
  logic       FrameErr;
  logic       Busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int n_valid      = 0;
  int n_err        = 0;
  int n_busy       = 0;
  int n_both       = 0;
  int last_valid   = 0;
  int first_valid  = 0;

  serial_frame_rx #(.WIDTH(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .D        (D),
    .Q        (Q),
    .Valid    (Valid),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_err   = 0;
    n_busy  = 0;
  endtask

  task automatic send_bit(input logic b);
    D = b;
    @(posedge Clock);
    #1;
    cyc++;
    if (Valid) begin
      n_valid++;
      last_valid = cyc;
    end
    if (FrameErr) n_err++;
    if (Busy) n_busy++;
    if (Valid && FrameErr) n_both++;
  endtask

  // Start bit, 8 data bits LSB first, parity bit (parity builds only), stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef SERIAL_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) D = 1'b1;
`endif
    send_bit(stop);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_ferr", 32'(FrameErr), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    Reset = 1'b1;

    // Idle line for 20 cycles
    clr_counts();
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    chk("idle_valid", 32'(n_valid), 32'd0);
    chk("idle_err", 32'(n_err), 32'd0);
    chk("idle_busy", 32'(n_busy), 32'd0);
    chk("idle_q", 32'(Q), 32'h0);

    // Single frame 0xA5
    clr_counts();
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_valid", 32'(Valid), 32'h1);
    chk("a5_q", 32'(Q), 32'hA5);
    chk("a5_busy_end", 32'(Busy), 32'h0);
    send_bit(1'b1);
    chk("a5_valid_1cyc", 32'(Valid), 32'h0);
    chk("a5_nvalid", 32'(n_valid), 32'd1);
    chk("a5_busy_cycles", 32'(n_busy), 32'(FLEN - 1));

    // Back-to-back 0x3C then 0xC3
    clr_counts();
    send_frame(8'h3C, 1'b1, 1'b0);
    first_valid = last_valid;
    chk("b2b_q1", 32'(Q), 32'h3C);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("b2b_q2", 32'(Q), 32'hC3);
    chk("b2b_gap", 32'(last_valid - first_valid), 32'(FLEN));
    chk("b2b_nvalid", 32'(n_valid), 32'd2);

    // 0x5A with bad stop bit, then an immediate good frame
    clr_counts();
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("stop_ferr", 32'(FrameErr), 32'h1);
    chk("stop_valid", 32'(Valid), 32'h0);
    chk("stop_q_hold", 32'(Q), 32'hC3);
    send_frame(8'h96, 1'b1, 1'b0);
    chk("after_err_q", 32'(Q), 32'h96);
    chk("after_err_valid", 32'(Valid), 32'h1);
    chk("after_err_nerr", 32'(n_err), 32'd1);

    // Reset after 4th data bit of 0xFF, then frame 0x81
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    Reset = 1'b0;
    #1;
    chk("mid_rst_q", 32'(Q), 32'h0);
    chk("mid_rst_busy", 32'(Busy), 32'h0);
    chk("mid_rst_valid", 32'(Valid), 32'h0);
    chk("mid_rst_ferr", 32'(FrameErr), 32'h0);
    D = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    clr_counts();
    send_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("post_rst_q", 32'(Q), 32'h81);
    chk("post_rst_nvalid", 32'(n_valid), 32'd1);
    chk("post_rst_nerr", 32'(n_err), 32'd0);

`ifdef SERIAL_PARITY_EN
    // Even parity: 0xA5 has four ones, so parity bit 0 is correct.
    clr_counts();
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("par_ok_valid", 32'(Valid), 32'h1);
    chk("par_ok_q", 32'(Q), 32'hA5);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("par_ok2_q", 32'(Q), 32'h3C);
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("par_bad_ferr", 32'(FrameErr), 32'h1);
    chk("par_bad_valid", 32'(Valid), 32'h0);
    chk("par_bad_q_hold", 32'(Q), 32'h3C);
`endif

    chk("never_both", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
